// File: rtl/reg_native_pkg.sv
// Shared types for the AXI4-Lite to native register bridge.
//   state_e     : request/response sequencer states
//   RESP_OKAY   : AXI OKAY response code
//   RESP_SLVERR : AXI SLVERR response code
package reg_native_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_RESP = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Map a native error flag onto an AXI response code.
  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/reg_axi_chan_buf.sv
// Single-entry valid/ready capture register for one AXI channel.
//   clk, rst : clock, asynchronous active-high reset
//   valid    : upstream valid
//   ready    : registered ready, equals !full once out of reset
//   data     : payload captured on the handshake
//   clr      : empties the entry (owner has finished with it)
//   full     : entry holds a payload
//   q        : captured payload
module reg_axi_chan_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  output logic             ready,
  input  logic [WIDTH-1:0] data,
  input  logic             clr,
  output logic             full,
  output logic [WIDTH-1:0] q
);

  logic load;
  logic full_d;

  // Load and clear never coincide: load needs an empty entry, clr a full one.
  assign load   = valid && ready;
  assign full_d = load || (full && !clr);

  // Ready is the registered complement of the next full state, so it is low
  // during reset and drops in the same edge as the capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      ready <= 1'b0;
      q     <= '0;
    end else begin
      full  <= full_d;
      ready <= !full_d;
      if (load) q <= data;
    end
  end

endmodule

// File: rtl/reg_axi4lite2native_if.sv
// AXI4-Lite slave turning register accesses into single native requests.
// One access outstanding at a time; read/write contention alternates.
//   clk, rst                          : clock, asynchronous active-high reset
//   aw*/w*/b*, ar*/r*                 : AXI4-Lite slave channels
//   req_vld/wr_en/rd_en/addr/wr_data  : native request (req_vld masked by ack_vld)
//   ack_vld/rd_data/err               : native completion, one-cycle pulse
// DATA_WIDTH must be 32 or 64.
module reg_axi4lite2native_if
  import reg_native_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = 48,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  req_vld,
  input  logic                  ack_vld,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  err
);

  localparam int unsigned WBUF_WIDTH = DATA_WIDTH + STRB_WIDTH;

  logic                  aw_full, w_full, ar_full;
  logic                  aw_clr, w_clr, ar_clr;
  logic [ADDR_WIDTH-1:0] aw_q, ar_q;
  logic [WBUF_WIDTH-1:0] w_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  state_e                state_q, state_d;
  logic                  last_wr_q, last_wr_d;
  logic                  bvalid_d, rvalid_d;
  logic [1:0]            bresp_d, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  wr_ok, rd_ok, grant_rd;

  // Channel capture buffers
  reg_axi_chan_buf #(.WIDTH(ADDR_WIDTH)) u_aw_buf (
    .clk(clk), .rst(rst), .valid(awvalid), .ready(awready), .data(awaddr),
    .clr(aw_clr), .full(aw_full), .q(aw_q)
  );

  reg_axi_chan_buf #(.WIDTH(WBUF_WIDTH)) u_w_buf (
    .clk(clk), .rst(rst), .valid(wvalid), .ready(wready), .data({wstrb, wdata}),
    .clr(w_clr), .full(w_full), .q(w_q)
  );

  reg_axi_chan_buf #(.WIDTH(ADDR_WIDTH)) u_ar_buf (
    .clk(clk), .rst(rst), .valid(arvalid), .ready(arready), .data(araddr),
    .clr(ar_clr), .full(ar_full), .q(ar_q)
  );

  assign wdata_q = w_q[DATA_WIDTH-1:0];
  assign wstrb_q = w_q[WBUF_WIDTH-1:DATA_WIDTH];

  // Arbitration: a read wins a tie only when the previous grant was a write.
  assign wr_ok    = aw_full && w_full;
  assign rd_ok    = ar_full;
  assign grant_rd = rd_ok && (!wr_ok || last_wr_q);

  // Native request; req_vld drops in the ack cycle so the bridge cannot relaunch.
  assign req_vld = ((state_q == ST_WR_REQ) || (state_q == ST_RD_REQ)) && !ack_vld;
  assign wr_en   = (state_q == ST_WR_REQ);
  assign rd_en   = (state_q == ST_RD_REQ);
  assign addr    = (state_q == ST_WR_REQ) ? aw_q :
                   (state_q == ST_RD_REQ) ? ar_q : '0;
  assign wr_data = (state_q == ST_WR_REQ) ? wdata_q : '0;

  // State and registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_wr_q <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      rvalid    <= 1'b0;
      rresp     <= RESP_OKAY;
      rdata     <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      bvalid    <= bvalid_d;
      bresp     <= bresp_d;
      rvalid    <= rvalid_d;
      rresp     <= rresp_d;
      rdata     <= rdata_d;
    end
  end

  // Next-state, next-output and buffer release
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    bvalid_d  = bvalid;
    bresp_d   = bresp;
    rvalid_d  = rvalid;
    rresp_d   = rresp;
    rdata_d   = rdata;
    aw_clr    = 1'b0;
    w_clr     = 1'b0;
    ar_clr    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_rd) begin
          last_wr_d = 1'b0;
          state_d   = ST_RD_REQ;
        end else if (wr_ok) begin
          last_wr_d = 1'b1;
          // Partial strobes are refused locally without touching the native side.
          if (wstrb_q != {STRB_WIDTH{1'b1}}) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_SLVERR;
            state_d  = ST_WR_RESP;
          end else begin
            state_d  = ST_WR_REQ;
          end
        end
      end

      ST_WR_REQ: begin
        if (ack_vld) begin
          bvalid_d = 1'b1;
          bresp_d  = resp_of(err);
          state_d  = ST_WR_RESP;
        end
      end

      ST_RD_REQ: begin
        if (ack_vld) begin
          rvalid_d = 1'b1;
          rresp_d  = resp_of(err);
          rdata_d  = rd_data;
          state_d  = ST_RD_RESP;
        end
      end

      ST_WR_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          aw_clr   = 1'b1;
          w_clr    = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      ST_RD_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          ar_clr   = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_axi4lite2native_if.sv
// Self-checking bench for reg_axi4lite2native_if. Inputs are driven on the
// falling edge and outputs sampled 1ns later; expected AXI responses are
// queued when the native completion is driven and popped at the response.
module tb_reg_axi4lite2native_if;

  localparam int unsigned AW = 48;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic          bready = 1'b0, rready = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          awready, wready, arready, bvalid, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;
  logic          req_vld, wr_en, rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          ack_vld = 1'b0, err = 1'b0;
  logic [DW-1:0] rd_data = '0;

  typedef struct {
    logic          is_rd;
    logic [1:0]    resp;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   req_cnt  = 0;
  int   b_cnt    = 0;

  always #5 clk = ~clk;

  reg_axi4lite2native_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .req_vld(req_vld), .ack_vld(ack_vld), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .err(err)
  );

  // Count native launches and write responses seen at clock edges.
  always @(posedge clk) begin
    if (req_vld) req_cnt <= req_cnt + 1;
    if (bvalid)  b_cnt   <= b_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({awready, wready, arready, bvalid, rvalid, req_vld, wr_en, rd_en}), 64'(0));
    check({tag, "_addr"}, 64'(addr), 64'(0));
    check({tag, "_wdata"}, 64'(wr_data), 64'(0));
    check({tag, "_resp"}, 64'({bresp, rresp, rdata}), 64'(0));
  endtask

  task automatic send_aw_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    @(negedge clk);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    #1 check("aw_w_ready", 64'({awready, wready}), 64'(2'b11));
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic send_all(input logic [AW-1:0] wa, input logic [DW-1:0] d, input logic [AW-1:0] ra);
    @(negedge clk);
    awvalid = 1'b1; awaddr = wa; wvalid = 1'b1; wdata = d; wstrb = '1;
    arvalid = 1'b1; araddr = ra;
    #1 check("all_ready", 64'({awready, wready, arready}), 64'(3'b111));
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [AW-1:0] a);
    int i;
    @(negedge clk);
    arvalid = 1'b1; araddr = a;
    #1;
    for (i = 0; i < 20 && !arready; i++) begin @(negedge clk); #1; end
    if (!arready) check("ar_timeout", 64'(0), 64'(1));
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  // Act as the native slave: check the request, then complete it after dly cycles.
  task automatic serve(input logic is_rd, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int dly, input logic [DW-1:0] rd, input logic e);
    int i;
    #1;
    for (i = 0; i < 20 && !req_vld; i++) begin @(negedge clk); #1; end
    check("req_seen", 64'(req_vld), 64'(1));
    check("req_dir", 64'({wr_en, rd_en}), is_rd ? 64'(2'b01) : 64'(2'b10));
    check("req_addr", 64'(addr), 64'(a));
    if (!is_rd) check("req_wdata", 64'(wr_data), 64'(wd));
    repeat (dly) @(negedge clk);
    @(negedge clk);
    ack_vld = 1'b1; rd_data = rd; err = e;
    #1 check("ack_mask", 64'(req_vld), 64'(0));
    exp_q.push_back('{is_rd: is_rd, resp: (e ? 2'b10 : 2'b00), data: (is_rd ? rd : '0)});
    @(negedge clk);
    ack_vld = 1'b0; rd_data = '0; err = 1'b0;
  endtask

  // Pop the next expected response, hold ready low for 'hold' cycles, then handshake.
  task automatic wait_resp(input int hold);
    exp_t e;
    int   i;
    #1;
    for (i = 0; i < 20 && !(bvalid || rvalid); i++) begin @(negedge clk); #1; end
    if (!(bvalid || rvalid)) begin
      check("resp_timeout", 64'(0), 64'(1));
      return;
    end
    if (exp_q.size() == 0) begin
      check("resp_unexpected", 64'(1), 64'(0));
      return;
    end
    e = exp_q.pop_front();
    check("resp_chan", 64'({rvalid, bvalid}), e.is_rd ? 64'(2'b10) : 64'(2'b01));
    if (e.is_rd) begin
      check("rresp", 64'(rresp), 64'(e.resp));
      check("rdata", 64'(rdata), 64'(e.data));
    end else begin
      check("bresp", 64'(bresp), 64'(e.resp));
    end
    repeat (hold) begin
      @(negedge clk); #1;
      if (e.is_rd) begin
        check("r_hold", 64'({rvalid, rresp, rdata}), 64'({1'b1, e.resp, e.data}));
        check("ar_busy", 64'(arready), 64'(0));
      end else begin
        check("b_hold", 64'({bvalid, bresp}), 64'({1'b1, e.resp}));
        check("aw_w_busy", 64'({awready, wready}), 64'(0));
      end
    end
    @(negedge clk);
    if (e.is_rd) rready = 1'b1; else bready = 1'b1;
    #1;
    if (e.is_rd) check("ar_busy_hs", 64'(arready), 64'(0));
    else         check("w_busy_hs", 64'(wready), 64'(0));
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    #1;
    if (e.is_rd) begin
      check("r_done", 64'(rvalid), 64'(0));
      check("ar_free", 64'(arready), 64'(1));
    end else begin
      check("b_done", 64'(bvalid), 64'(0));
      check("aw_w_free", 64'({awready, wready}), 64'(2'b11));
    end
  endtask

  initial begin : main
    int r0;
    int b0;
    int i;

    // Reset state
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("ready_after_reset", 64'({awready, wready, arready}), 64'(3'b111));

    // Contention straight after reset: write goes first, then the buffered read
    send_all(48'h20, 32'h0102_0304, 48'h24);
    serve(1'b0, 48'h20, 32'h0102_0304, 0, '0, 1'b0);
    wait_resp(0);
    serve(1'b1, 48'h24, '0, 0, 32'h55AA_55AA, 1'b0);
    wait_resp(0);

    // Plain write with exact latencies; leaves last grant = write
    send_aw_w(48'h100, 32'hDEAD_BEEF, 4'hF);
    #1 check("wr_req_t0", 64'(req_vld), 64'(0));
    @(negedge clk); #1;
    check("wr_req_t1", 64'({req_vld, wr_en}), 64'(2'b11));
    serve(1'b0, 48'h100, 32'hDEAD_BEEF, 2, '0, 1'b0);
    #1 check("bvalid_ack_plus1", 64'(bvalid), 64'(1));
    wait_resp(0);

    // Both pending again with last grant = write: read goes first
    send_all(48'h40, 32'h0BAD_F00D, 48'h44);
    serve(1'b1, 48'h44, '0, 1, 32'hA1B2_C3D4, 1'b0);
    wait_resp(0);
    serve(1'b0, 48'h40, 32'h0BAD_F00D, 0, '0, 1'b0);
    wait_resp(0);

    // Read with native error, R held for 4 cycles
    send_ar(48'h200);
    #1 check("ar_busy_after_cap", 64'(arready), 64'(0));
    serve(1'b1, 48'h200, '0, 1, 32'h1234_5678, 1'b1);
    wait_resp(4);

    // Partial strobe: refused with SLVERR, no native request
    r0 = req_cnt;
    send_aw_w(48'h10, 32'hA5A5_A5A5, 4'h3);
    exp_q.push_back('{is_rd: 1'b0, resp: 2'b10, data: '0});
    wait_resp(0);
    check("partial_no_req", 64'(req_cnt), 64'(r0));

    // W first, AW three cycles later
    @(negedge clk);
    wvalid = 1'b1; wdata = 32'hCAFE_0001; wstrb = '1;
    #1 check("w_first_ready", 64'(wready), 64'(1));
    @(negedge clk);
    wvalid = 1'b0;
    #1 check("w_first_busy", 64'(wready), 64'(0));
    @(negedge clk); #1;
    check("w_first_noreq", 64'(req_vld), 64'(0));
    @(negedge clk);
    awvalid = 1'b1; awaddr = 48'h8000_0000_0300;
    #1 check("aw_late_ready", 64'(awready), 64'(1));
    @(negedge clk);
    awvalid = 1'b0;
    #1 check("w_first_t3", 64'({req_vld, wready}), 64'(0));
    @(negedge clk); #1;
    check("w_first_t4", 64'({req_vld, wready}), 64'(2'b10));
    serve(1'b0, 48'h8000_0000_0300, 32'hCAFE_0001, 0, '0, 1'b0);
    wait_resp(1);

    // Reset during WR_REQ drops the write; a fresh read still works
    send_aw_w(48'h300, 32'h1111_2222, 4'hF);
    #1;
    for (i = 0; i < 20 && !req_vld; i++) begin @(negedge clk); #1; end
    check("midop_req", 64'(req_vld), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    #1 check_all_zero("midop_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r0 = req_cnt;
    b0 = b_cnt;
    repeat (5) @(negedge clk);
    check("midop_no_b", 64'(b_cnt), 64'(b0));
    check("midop_no_req", 64'(req_cnt), 64'(r0));
    send_ar(48'h400);
    serve(1'b1, 48'h400, '0, 1, 32'hCAFE_F00D, 1'b0);
    wait_resp(0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
